// File: rtl/tia_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tia_video_pkg
// Purpose  : Shared types and constants for the TIA video output block:
//            NTSC and PAL 128-entry 24-bit RGB palettes, the frame-lock
//            state encoding and the {col,lum} palette index helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tia_video_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  localparam int c_pal_entries = 128;

  // Row n holds hue n, luminance 0..7 left to right.
  localparam logic [23:0] c_ntsc_palette [c_pal_entries] = '{
    24'h000000, 24'h4a4a4a, 24'h6f6f6f, 24'h8e8e8e, 24'haaaaaa, 24'hc0c0c0, 24'hd6d6d6, 24'hececec,
    24'h484800, 24'h69690f, 24'h86861d, 24'ha2a22a, 24'hbbbb35, 24'hd2d240, 24'he8e84a, 24'hfcfc54,
    24'h7c2c00, 24'h904811, 24'ha26221, 24'hb47a30, 24'hc3903d, 24'hd2a44a, 24'hdfb755, 24'hecc860,
    24'h901c00, 24'ha33915, 24'hb55328, 24'hc66c3a, 24'hd5824a, 24'he39759, 24'hf0aa67, 24'hfcbc74,
    24'h940000, 24'ha71a1a, 24'hb83232, 24'hc84848, 24'hd65c5c, 24'he46f6f, 24'hf08080, 24'hfc9090,
    24'h840064, 24'h97197a, 24'ha8308f, 24'hb846a2, 24'hc659b3, 24'hd46cc3, 24'he07cd2, 24'hec8ce0,
    24'h500084, 24'h68199a, 24'h7d30ad, 24'h9246c0, 24'ha459d0, 24'hb56ce0, 24'hc57cee, 24'hd48cfc,
    24'h140090, 24'h331aa3, 24'h4e32b5, 24'h6848c6, 24'h7f5cd5, 24'h956fe3, 24'ha980f0, 24'hbc90fc,
    24'h000094, 24'h181aa7, 24'h2d32b8, 24'h4248c8, 24'h545cd6, 24'h656fe4, 24'h7580f0, 24'h8490fc,
    24'h001c88, 24'h183b9d, 24'h2d57b0, 24'h4272c2, 24'h548ad2, 24'h65a0e1, 24'h75b5ef, 24'h84c8fc,
    24'h003064, 24'h185080, 24'h2d6d98, 24'h4288b0, 24'h54a0c5, 24'h65b7d9, 24'h75cceb, 24'h84e0fc,
    24'h004030, 24'h18624e, 24'h2d8169, 24'h429e82, 24'h54b899, 24'h65d1ae, 24'h75e7c2, 24'h84fcd4,
    24'h004400, 24'h1a661a, 24'h328432, 24'h48a048, 24'h5cba5c, 24'h6fd26f, 24'h80e880, 24'h90fc90,
    24'h143c00, 24'h355f18, 24'h527e2d, 24'h6e9c42, 24'h87b754, 24'h9ed065, 24'hb4e775, 24'hc8fc84,
    24'h303800, 24'h505916, 24'h6d762b, 24'h88923e, 24'ha0ab4f, 24'hb7c25f, 24'hccd86e, 24'he0ec7c,
    24'h482c00, 24'h694d14, 24'h866a26, 24'ha28638, 24'hbb9f47, 24'hd2b656, 24'he8cc63, 24'hfce070
  };

  // PAL has no chroma on hues 0, 1, 13, 14 and 15; those rows are grey.
  localparam logic [23:0] c_pal_palette [c_pal_entries] = '{
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h805800, 24'h947020, 24'ha8843c, 24'hbc9c58, 24'hccac70, 24'hdcc084, 24'hecd09c, 24'hfce0b0,
    24'h445c00, 24'h5c7820, 24'h74903c, 24'h8cac58, 24'ha0c070, 24'hb0d484, 24'hc4e89c, 24'hd4fcb0,
    24'h703400, 24'h885020, 24'ha0683c, 24'hb48458, 24'hc89870, 24'hdcac84, 24'hecc09c, 24'hfcd4b0,
    24'h006414, 24'h208034, 24'h3c9850, 24'h58b06c, 24'h70c484, 24'h84d89c, 24'h9ce8b4, 24'hb0fcc8,
    24'h700014, 24'h882034, 24'ha03c50, 24'hb4586c, 24'hc87084, 24'hdc849c, 24'hec9cb4, 24'hfcb0c8,
    24'h005c5c, 24'h207474, 24'h3c8c8c, 24'h58a4a4, 24'h70b8b8, 24'h84c8c8, 24'h9cdcdc, 24'hb0ecec,
    24'h70005c, 24'h842074, 24'h943c88, 24'ha8589c, 24'hb470b0, 24'hc484c0, 24'hd09cd0, 24'he0b0e0,
    24'h003c70, 24'h1c5888, 24'h3874a0, 24'h508cb4, 24'h68a4c8, 24'h7cb8dc, 24'h90ccec, 24'ha4e0fc,
    24'h580070, 24'h6c2088, 24'h803ca0, 24'h9458b4, 24'ha470c8, 24'hb484dc, 24'hc49cec, 24'hd4b0fc,
    24'h002070, 24'h1c3c88, 24'h3858a0, 24'h5074b4, 24'h6888c8, 24'h7ca0dc, 24'h90b4ec, 24'ha4c8fc,
    24'h3c0080, 24'h542094, 24'h6c3ca8, 24'h8058bc, 24'h9470cc, 24'ha884dc, 24'hb89cec, 24'hc8b0fc,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec
  };

  function automatic logic [6:0] pal_index(input logic [3:0] col, input logic [2:0] lum);
    return {col, lum};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tia_frame_lock.sv
`default_nettype none
// ============================================================================
// Module   : tia_frame_lock
// Purpose  : Rebuilds stable vertical timing from TIA syncs. Detects hsync and
//            vsync rising edges on video_ce strobes, counts lines, inserts a
//            synthetic vsync when a frame runs to MAX_LINES, runs the lock FSM
//            and derives the fixed vertical display window.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            video_ce_i         - pixel strobe, all state advances only when high
//            hsync_i, vsync_i   - raw TIA syncs
//            line_cnt_o         - current line (saturating at 511)
//            frame_lines_o      - length of the last completed frame
//            synth_vs_o         - synthetic vsync active (3 lines)
//            locked_o           - FSM in LOCKED
//            win_vb_o           - 1 when line_cnt_o is outside the display window
// Revision : 1.0 - initial release
// ============================================================================
module tia_frame_lock
  import tia_video_pkg::*;
#(
  parameter int MIN_LINES = 200,
  parameter int MAX_LINES = 320,
  parameter int LOCK_TOL  = 4,
  parameter int MISS_MAX  = 3,
  parameter int V_START   = 34,
  parameter int V_ACTIVE  = 210
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_ce_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  output logic [8:0] line_cnt_o,
  output logic [8:0] frame_lines_o,
  output logic       synth_vs_o,
  output logic       locked_o,
  output logic       win_vb_o
);

  localparam int           c_miss_w     = $clog2(MISS_MAX + 1);
  localparam logic [8:0]   c_min_lines  = 9'(MIN_LINES);
  localparam logic [8:0]   c_max_lines  = 9'(MAX_LINES);
  localparam logic [8:0]   c_max_m1     = 9'(MAX_LINES - 1);
  localparam logic [9:0]   c_lock_tol   = 10'(LOCK_TOL);
  localparam logic [8:0]   c_v_start    = 9'(V_START);
  localparam logic [9:0]   c_v_end      = 10'(V_START + V_ACTIVE);
  localparam logic [c_miss_w-1:0] c_miss_last = c_miss_w'(MISS_MAX - 1);

  logic                hsync_q, vsync_q;
  logic [8:0]          line_cnt_q, line_cnt_d;
  logic [8:0]          frame_lines_q, frame_lines_d;
  logic [8:0]          locked_lines_q, locked_lines_d;
  logic [1:0]          synth_lines_q, synth_lines_d;
  logic [c_miss_w-1:0] miss_q, miss_d;
  lock_state_t         state_q, state_d;

  logic                hs_rise, vs_rise, synth_edge, frame_edge;
  logic [8:0]          frame_count;
  logic signed [9:0]   diff;
  logic [9:0]          abs_diff;
  logic                in_range, within_tol;

  assign hs_rise    = video_ce_i & hsync_i & ~hsync_q;
  assign vs_rise    = video_ce_i & vsync_i & ~vsync_q;
  // The hsync that would take the count to MAX_LINES closes the frame instead.
  assign synth_edge = hs_rise & ~vs_rise & (line_cnt_q == c_max_m1);
  assign frame_edge = vs_rise | synth_edge;
  assign frame_count = synth_edge ? c_max_lines : line_cnt_q;

  assign diff       = $signed({1'b0, frame_count}) - $signed({1'b0, locked_lines_q});
  assign abs_diff   = diff[9] ? 10'(-diff) : 10'(diff);
  assign within_tol = (abs_diff <= c_lock_tol);
  assign in_range   = (frame_count >= c_min_lines) && (frame_count <= c_max_lines);

  // Line counter, frame length capture and synthetic vsync stretch.
  always_comb begin
    line_cnt_d    = line_cnt_q;
    frame_lines_d = frame_lines_q;
    synth_lines_d = synth_lines_q;
    if (vs_rise) begin
      line_cnt_d    = 9'd0;
      frame_lines_d = line_cnt_q;
      synth_lines_d = 2'd0;
    end else if (synth_edge) begin
      line_cnt_d    = 9'd0;
      frame_lines_d = c_max_lines;
      synth_lines_d = 2'd3;
    end else if (hs_rise) begin
      if (line_cnt_q != 9'd511) begin
        line_cnt_d = line_cnt_q + 9'd1;
      end
      if (synth_lines_q != 2'd0) begin
        synth_lines_d = synth_lines_q - 2'd1;
      end
    end
  end

  // Lock FSM next state.
  always_comb begin
    state_d        = state_q;
    miss_d         = miss_q;
    locked_lines_d = locked_lines_q;
    if (frame_edge) begin
      case (state_q)
        SEARCH: begin
          state_d = MEASURE;
        end
        MEASURE: begin
          if (in_range && !synth_edge) begin
            state_d        = LOCKED;
            locked_lines_d = frame_count;
            miss_d         = '0;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (within_tol && vs_rise) begin
            miss_d         = '0;
            locked_lines_d = frame_count;
          end else if (miss_q == c_miss_last) begin
            state_d = SEARCH;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q        <= 1'b0;
      vsync_q        <= 1'b0;
      line_cnt_q     <= 9'd0;
      frame_lines_q  <= 9'd0;
      locked_lines_q <= 9'd0;
      synth_lines_q  <= 2'd0;
      miss_q         <= '0;
      state_q        <= SEARCH;
    end else if (video_ce_i) begin
      hsync_q        <= hsync_i;
      vsync_q        <= vsync_i;
      line_cnt_q     <= line_cnt_d;
      frame_lines_q  <= frame_lines_d;
      locked_lines_q <= locked_lines_d;
      synth_lines_q  <= synth_lines_d;
      miss_q         <= miss_d;
      state_q        <= state_d;
    end
  end

  assign line_cnt_o    = line_cnt_q;
  assign frame_lines_o = frame_lines_q;
  assign synth_vs_o    = (synth_lines_q != 2'd0);
  assign locked_o      = (state_q == LOCKED);
  assign win_vb_o      = !((line_cnt_q >= c_v_start) && ({1'b0, line_cnt_q} < c_v_end));

endmodule
`default_nettype wire

// File: rtl/tia_video_out.sv
`default_nettype none
// ============================================================================
// Module   : tia_video_out
// Purpose  : Consumer end of the TIA video interface. Stage 1 registers the
//            TIA signals (edge detection lives in tia_frame_lock), stage 2
//            reads the palette ROM and registers RGB together with the
//            delayed syncs and blanks, so every output has the same 2-strobe
//            latency. Vertical blank comes from the lock window when locked.
// Ports    : clk, reset                - clock, synchronous active-high reset
//            video_ce                  - pixel strobe
//            col[3:0], lum[2:0]        - TIA hue / luminance
//            hblank, vblank            - TIA blanks
//            hsync, vsync              - TIA syncs
//            r, g, b [7:0]             - pixel colour, 0 when blanked
//            hs_out, vs_out            - syncs aligned with RGB
//            hb_out, vb_out            - blanks aligned with RGB
//            locked                    - frame lock achieved
//            line_cnt[8:0]             - current line
//            frame_lines[8:0]          - length of last completed frame
// Revision : 1.0 - initial release
// ============================================================================
module tia_video_out
  import tia_video_pkg::*;
#(
  parameter int PAL_MODE  = 0,
  parameter int MIN_LINES = 200,
  parameter int MAX_LINES = 320,
  parameter int LOCK_TOL  = 4,
  parameter int MISS_MAX  = 3,
  parameter int V_START   = 34,
  parameter int V_ACTIVE  = 210
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_ce,
  input  logic [3:0] col,
  input  logic [2:0] lum,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       hsync,
  input  logic       vsync,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hs_out,
  output logic       vs_out,
  output logic       hb_out,
  output logic       vb_out,
  output logic       locked,
  output logic [8:0] line_cnt,
  output logic [8:0] frame_lines
);

  // Stage 1
  logic [6:0]  s1_idx_q;
  logic        s1_hblank_q, s1_vblank_q, s1_hsync_q, s1_vsync_q;
  // Stage 2
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;

  logic [23:0] rom_rgb;
  logic        synth_vs, locked_w, win_vb;

  tia_frame_lock #(
    .MIN_LINES (MIN_LINES),
    .MAX_LINES (MAX_LINES),
    .LOCK_TOL  (LOCK_TOL),
    .MISS_MAX  (MISS_MAX),
    .V_START   (V_START),
    .V_ACTIVE  (V_ACTIVE)
  ) u_frame_lock (
    .clk           (clk),
    .reset         (reset),
    .video_ce_i    (video_ce),
    .hsync_i       (hsync),
    .vsync_i       (vsync),
    .line_cnt_o    (line_cnt),
    .frame_lines_o (frame_lines),
    .synth_vs_o    (synth_vs),
    .locked_o      (locked_w),
    .win_vb_o      (win_vb)
  );

  generate
    if (PAL_MODE != 0) begin : g_pal_rom
      assign rom_rgb = c_pal_palette[s1_idx_q];
    end else begin : g_ntsc_rom
      assign rom_rgb = c_ntsc_palette[s1_idx_q];
    end
  endgenerate

  // The frame-lock counters advance on the same strobe as stage 1, so the
  // window and synthetic vsync line up with the stage-1 pixel here.
  always_comb begin
    hb_d  = s1_hblank_q;
    vb_d  = locked_w ? win_vb : s1_vblank_q;
    hs_d  = s1_hsync_q;
    vs_d  = s1_vsync_q | synth_vs;
    rgb_d = (hb_d || vb_d) ? 24'h000000 : rom_rgb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_idx_q    <= 7'd0;
      s1_hblank_q <= 1'b1;
      s1_vblank_q <= 1'b1;
      s1_hsync_q  <= 1'b0;
      s1_vsync_q  <= 1'b0;
      rgb_q       <= 24'h000000;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hb_q        <= 1'b1;
      vb_q        <= 1'b1;
    end else if (video_ce) begin
      s1_idx_q    <= pal_index(col, lum);
      s1_hblank_q <= hblank;
      s1_vblank_q <= vblank;
      s1_hsync_q  <= hsync;
      s1_vsync_q  <= vsync;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hb_q        <= hb_d;
      vb_q        <= vb_d;
    end
  end

  assign r      = rgb_q[23:16];
  assign g      = rgb_q[15:8];
  assign b      = rgb_q[7:0];
  assign hs_out = hs_q;
  assign vs_out = vs_q;
  assign hb_out = hb_q;
  assign vb_out = vb_q;
  assign locked = locked_w;

endmodule
`default_nettype wire

// File: tb/tb_tia_video_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_tia_video_out
// Purpose  : Self-checking bench for tia_video_out: pixel pipeline vectors
//            through a scoreboard, then frame-lock, synthetic vsync, edge and
//            reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tia_video_out;

  logic       clk = 1'b0;
  logic       reset, video_ce;
  logic [3:0] col;
  logic [2:0] lum;
  logic       hblank, vblank, hsync, vsync;
  logic [7:0] r, g, b;
  logic       hs_out, vs_out, hb_out, vb_out, locked;
  logic [8:0] line_cnt, frame_lines;

  int n_pass  = 0;
  int n_total = 0;
  bit idle_noise = 1'b0;

  typedef struct {
    logic [3:0]  col;
    logic [2:0]  lum;
    logic        hb, vb, hs, vs;
    logic [23:0] rgb;
  } vec_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs, vs, hb, vb;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  tia_video_out dut (
    .clk(clk), .reset(reset), .video_ce(video_ce),
    .col(col), .lum(lum), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b),
    .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
    .locked(locked), .line_cnt(line_cnt), .frame_lines(frame_lines)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One video_ce strobe; optional idle cycles with junk inputs that must be ignored.
  task automatic tick(input logic [3:0] c, input logic [2:0] l,
                      input logic hb, input logic vb, input logic hs, input logic vs);
    int n;
    col = c; lum = l; hblank = hb; vblank = vb; hsync = hs; vsync = vs;
    video_ce = 1'b1;
    @(posedge clk); #1;
    video_ce = 1'b0;
    if (idle_noise) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        col = 4'($urandom); lum = 3'($urandom);
        hblank = 1'($urandom); vblank = 1'($urandom);
        hsync = 1'($urandom); vsync = 1'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic sb_tick(input vec_t v);
    exp_t e;
    tick(v.col, v.lum, v.hb, v.vb, v.hs, v.vs);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("pix_rgb", {8'h00, r, g, b}, {8'h00, e.rgb});
      check("pix_flags", {28'd0, hs_out, vs_out, hb_out, vb_out},
            {28'd0, e.hs, e.vs, e.hb, e.vb});
    end
    sb.push_back('{rgb: v.rgb, hs: v.hs, vs: v.vs, hb: v.hb, vb: v.vb});
  endtask

  // n lines of 4 strobes each, hsync on the first strobe; vsync held for the
  // first vs_hold lines.
  task automatic lines(input int n, input logic vb, input int vs_hold);
    logic v;
    for (int i = 0; i < n; i++) begin
      v = (i < vs_hold);
      tick(4'h1, 3'h7, 1'b0, vb, 1'b1, v);
      for (int k = 0; k < 3; k++) tick(4'h1, 3'h7, 1'b0, vb, 1'b0, v);
    end
  endtask

  task automatic vsync_rise(input logic vb);
    tick(4'h1, 3'h7, 1'b0, vb, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1; video_ce = 1'b0;
    col = 4'h0; lum = 3'h0; hblank = 1'b0; vblank = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // {col, lum, hb, vb, hs, vs, expected NTSC rgb}
    vecs[0]  = '{4'h1, 3'h7, 1'b0, 1'b0, 1'b0, 1'b0, 24'hfcfc54};
    vecs[1]  = '{4'h0, 3'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[2]  = '{4'h0, 3'h7, 1'b0, 1'b0, 1'b0, 1'b0, 24'hececec};
    vecs[3]  = '{4'h4, 3'h3, 1'b0, 1'b0, 1'b0, 1'b0, 24'hc84848};
    vecs[4]  = '{4'h8, 3'h5, 1'b0, 1'b0, 1'b0, 1'b0, 24'h656fe4};
    vecs[5]  = '{4'hf, 3'h7, 1'b0, 1'b0, 1'b0, 1'b0, 24'hfce070};
    vecs[6]  = '{4'hc, 3'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h004400};
    vecs[7]  = '{4'h2, 3'h2, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[8]  = '{4'h3, 3'h4, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
    vecs[9]  = '{4'h7, 3'h6, 1'b0, 1'b0, 1'b1, 1'b0, 24'ha980f0};
    vecs[10] = '{4'h5, 3'h1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h97197a};
    vecs[11] = '{4'h0, 3'h0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

    // ---- Reset state
    do_reset();
    check("rst_rgb", {8'h00, r, g, b}, 32'h0);
    check("rst_syncs", {30'd0, hs_out, vs_out}, 32'h0);
    check("rst_blanks", {30'd0, hb_out, vb_out}, 32'h3);
    check("rst_locked", {31'd0, locked}, 32'h0);
    check("rst_line_cnt", {23'd0, line_cnt}, 32'h0);
    check("rst_frame_lines", {23'd0, frame_lines}, 32'h0);

    // ---- Pixel pipeline through the scoreboard (first output is the reset bubble)
    sb.push_back('{rgb: 24'h0, hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1});
    idle_noise = 1'b1;
    for (int i = 0; i < 12; i++) sb_tick(vecs[i]);
    sb_tick(vecs[11]);
    idle_noise = 1'b0;

    // ---- Lock on three 262-line frames
    do_reset();
    vsync_rise(1'b0);
    check("lock_after_vs1", {31'd0, locked}, 32'h0);
    lines(262, 1'b0, 3);
    check("line_cnt_262", {23'd0, line_cnt}, 32'd262);
    vsync_rise(1'b0);
    check("lock_after_vs2", {31'd0, locked}, 32'h1);
    check("frame_lines_262a", {23'd0, frame_lines}, 32'd262);
    // Locked frame with vblank input held high: window must drive vb_out.
    lines(33, 1'b1, 3);
    check("win_vb_line33", {31'd0, vb_out}, 32'h1);
    check("win_rgb_line33", {8'h00, r, g, b}, 32'h0);
    lines(1, 1'b1, 0);
    check("win_vb_line34", {31'd0, vb_out}, 32'h0);
    check("win_rgb_line34", {8'h00, r, g, b}, 32'h00fcfc54);
    lines(209, 1'b1, 0);
    check("win_vb_line243", {31'd0, vb_out}, 32'h0);
    lines(1, 1'b1, 0);
    check("win_vb_line244", {31'd0, vb_out}, 32'h1);
    lines(18, 1'b1, 0);
    vsync_rise(1'b1);
    check("lock_after_vs3", {31'd0, locked}, 32'h1);
    check("frame_lines_262b", {23'd0, frame_lines}, 32'd262);

    // ---- Three 270-line frames: two misses keep lock, the third drops it
    lines(270, 1'b0, 3);
    vsync_rise(1'b0);
    check("miss1_locked", {31'd0, locked}, 32'h1);
    check("frame_lines_270", {23'd0, frame_lines}, 32'd270);
    lines(270, 1'b0, 3);
    vsync_rise(1'b0);
    check("miss2_locked", {31'd0, locked}, 32'h1);
    lines(270, 1'b0, 3);
    vsync_rise(1'b0);
    check("miss3_unlocked", {31'd0, locked}, 32'h0);

    // ---- Relock, then reset mid-frame
    lines(262, 1'b0, 3);
    vsync_rise(1'b0);
    check("relock_measure", {31'd0, locked}, 32'h0);
    lines(262, 1'b0, 3);
    vsync_rise(1'b0);
    check("relock_locked", {31'd0, locked}, 32'h1);
    lines(50, 1'b0, 3);
    check("pre_reset_vb", {31'd0, vb_out}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_locked", {31'd0, locked}, 32'h0);
    check("midrst_line_cnt", {23'd0, line_cnt}, 32'h0);
    check("midrst_vb_out", {31'd0, vb_out}, 32'h1);
    check("midrst_frame_lines", {23'd0, frame_lines}, 32'h0);
    reset = 1'b0;

    // ---- No vsync: synthetic frame edge at 320 lines
    do_reset();
    lines(319, 1'b0, 0);
    check("syn_line_cnt_319", {23'd0, line_cnt}, 32'd319);
    check("syn_vs_before", {31'd0, vs_out}, 32'h0);
    lines(1, 1'b0, 0);
    check("syn_line_cnt_0", {23'd0, line_cnt}, 32'd0);
    check("syn_frame_lines", {23'd0, frame_lines}, 32'd320);
    check("syn_vs_on", {31'd0, vs_out}, 32'h1);
    lines(2, 1'b0, 0);
    check("syn_vs_line2", {31'd0, vs_out}, 32'h1);
    lines(1, 1'b0, 0);
    check("syn_vs_off", {31'd0, vs_out}, 32'h0);
    lines(7, 1'b0, 0);
    check("syn_no_lock", {31'd0, locked}, 32'h0);
    check("syn_frame_lines_hold", {23'd0, frame_lines}, 32'd320);

    // ---- hsync and vsync rising together; long vsync counts once
    do_reset();
    lines(5, 1'b0, 0);
    tick(4'h1, 3'h7, 1'b0, 1'b0, 1'b1, 1'b1);
    check("same_strobe_line_cnt", {23'd0, line_cnt}, 32'd0);
    check("same_strobe_frame_lines", {23'd0, frame_lines}, 32'd5);
    for (int k = 0; k < 3; k++) tick(4'h1, 3'h7, 1'b0, 1'b0, 1'b0, 1'b1);
    lines(3, 1'b0, 3);
    check("long_vs_line_cnt", {23'd0, line_cnt}, 32'd3);
    check("long_vs_frame_lines", {23'd0, frame_lines}, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
